// File: rtl/calc_mem_sequencer.sv
// -----------------------------------------------------------------------------
// calc_mem_sequencer
//
// Turns calculator commands into fixed bus transactions on the shared data
// memory that the ARM core polls. It also arbitrates that single memory port
// between the core and the calculator side.
//
// Command flow:
//   NUM1 / NUM2 : one write of the operand to its mailbox word, then respond.
//   OP          : write the operator code, write 1 to GO, then respond.
//   RESULT      : poll DONE until non-zero (or give up after POLL_LIMIT reads),
//                 read RES, clear DONE, then respond with the result.
// Every accepted command produces exactly one rsp_valid pulse.
//
// Arbitration: the core wins whenever it requests, unless the calculator has
// been blocked in a bus-use state for STARVE_LIMIT cycles. Then the calculator
// is forced through for one cycle. A blocked calculator simply holds its state.
//
// Ports:
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   cmd_valid/ready    command handshake; ready only while IDLE
//   cmd_op, cmd_data   0=NUM1, 1=NUM2, 2=OP, 3=RESULT; data ignored for RESULT
//   rsp_valid          one-cycle response pulse
//   rsp_data, rsp_err  result (RESULT only, else 0) and poll-timeout flag;
//                      both hold until the next accept
//   core_req/we/addr/wdata  core bus request for this cycle
//   core_gnt           combinational: the core owns the bus this cycle
//   core_rdata         mem_rdata passthrough (valid the cycle after a grant)
//   mem_we/addr/wdata  memory port; all zero when nobody uses the bus
//   mem_rdata          memory read data, one-cycle latency
//   busy               high whenever not IDLE
// -----------------------------------------------------------------------------
module calc_mem_sequencer #(
  parameter logic [31:0] NUM1_ADDR    = 32'd16,
  parameter logic [31:0] NUM2_ADDR    = 32'd20,
  parameter logic [31:0] OP_ADDR      = 32'd24,
  parameter logic [31:0] GO_ADDR      = 32'd28,
  parameter logic [31:0] DONE_ADDR    = 32'd32,
  parameter logic [31:0] RES_ADDR     = 32'd36,
  parameter int unsigned POLL_LIMIT   = 255,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  // core data port
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic [31:0] core_rdata,
  // memory port
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    OP_NUM1   = 2'd0,
    OP_NUM2   = 2'd1,
    OP_OPER   = 2'd2,
    OP_RESULT = 2'd3
  } cmd_op_t;

  typedef enum logic [3:0] {
    IDLE,
    WR_DATA,
    WR_GO,
    POLL_RD,
    POLL_CHK,
    RES_RD,
    RES_CAP,
    CLR_DONE,
    RSP
  } state_t;

  state_t              state;
  cmd_op_t             op_q;
  logic [31:0]         data_q;
  logic [7:0]          poll_cnt;
  logic [7:0]          poll_next;
  logic [STARVE_W-1:0] starve;

  // Calculator-side bus request derived from the current state.
  logic        calc_bus;
  logic        calc_we;
  logic [31:0] calc_addr;
  logic [31:0] calc_wdata;
  logic        calc_force;
  logic        calc_go;   // calculator owns the bus this cycle

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    calc_bus   = 1'b0;
    calc_we    = 1'b0;
    calc_addr  = '0;
    calc_wdata = '0;
    unique case (state)
      WR_DATA: begin
        calc_bus   = 1'b1;
        calc_we    = 1'b1;
        calc_wdata = data_q;
        unique case (op_q)
          OP_NUM1: calc_addr = NUM1_ADDR;
          OP_NUM2: calc_addr = NUM2_ADDR;
          default: calc_addr = OP_ADDR;
        endcase
      end
      WR_GO: begin
        calc_bus   = 1'b1;
        calc_we    = 1'b1;
        calc_addr  = GO_ADDR;
        calc_wdata = 32'd1;
      end
      POLL_RD: begin
        calc_bus  = 1'b1;
        calc_addr = DONE_ADDR;
      end
      RES_RD: begin
        calc_bus  = 1'b1;
        calc_addr = RES_ADDR;
      end
      CLR_DONE: begin
        calc_bus   = 1'b1;
        calc_we    = 1'b1;
        calc_addr  = DONE_ADDR;
        calc_wdata = 32'd0;
      end
      default: ;
    endcase
  end

  // The core is only refused when the calculator has waited long enough.
  assign calc_force = calc_bus & (starve >= STARVE_W'(STARVE_LIMIT));
  assign core_gnt   = core_req & ~calc_force;
  assign calc_go    = calc_bus & ~core_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (calc_bus) begin
      mem_we    = calc_we;
      mem_addr  = calc_addr;
      mem_wdata = calc_wdata;
    end
  end

  assign core_rdata = mem_rdata;
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign poll_next  = poll_cnt + 8'd1;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_NUM1;
      data_q    <= '0;
      poll_cnt  <= '0;
      starve    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;

      // Starvation counts only cycles in which the calculator wanted the bus
      // and lost it; any calculator win clears it.
      if (calc_bus) begin
        if (core_gnt) begin
          if (starve < STARVE_W'(STARVE_LIMIT)) starve <= starve + 1'b1;
        end else begin
          starve <= '0;
        end
      end

      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op_t'(cmd_op);
            data_q   <= cmd_data;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            poll_cnt <= '0;
            state    <= (cmd_op_t'(cmd_op) == OP_RESULT) ? POLL_RD : WR_DATA;
          end
        end
        WR_DATA: begin
          if (calc_go) begin
            if (op_q == OP_OPER) begin
              state <= WR_GO;
            end else begin
              state     <= RSP;
              rsp_valid <= 1'b1;
            end
          end
        end
        WR_GO: begin
          if (calc_go) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
          end
        end
        POLL_RD: begin
          if (calc_go) state <= POLL_CHK;
        end
        POLL_CHK: begin
          // mem_rdata here belongs to our DONE read from the previous cycle,
          // regardless of who owns the bus now.
          if (mem_rdata != 32'd0) begin
            state <= RES_RD;
          end else begin
            poll_cnt <= poll_next;
            if (poll_next == 8'(POLL_LIMIT)) begin
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_valid <= 1'b1;
              state     <= RSP;
            end else begin
              state <= POLL_RD;
            end
          end
        end
        RES_RD: begin
          if (calc_go) state <= RES_CAP;
        end
        RES_CAP: begin
          rsp_data <= mem_rdata;
          state    <= CLR_DONE;
        end
        CLR_DONE: begin
          if (calc_go) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
          end
        end
        RSP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
